// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the forwarding result pipeline: opcode constants,
// forwarding select encodings, instruction field positions, pipeline FSM state
// type and opcode classification helpers (is_load / is_writer).
// Instruction layout: [15:12] opcode, [11:8] op1 (dest), [7:4] op2.
// -----------------------------------------------------------------------------
package fwd_pkg;

    localparam int INST_W_FIXED = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ANDI = 4'h8;
    localparam logic [3:0] OP_ORI  = 4'h9;
    localparam logic [3:0] OP_LB   = 4'hA;
    localparam logic [3:0] OP_SB   = 4'hB;
    localparam logic [3:0] OP_LW   = 4'hC;
    localparam logic [3:0] OP_SW   = 4'hD;
    localparam logic [3:0] OP_ALU  = 4'hF;

    localparam logic [1:0] HAZ_RF  = 2'b00;
    localparam logic [1:0] HAZ_M   = 2'b01;
    localparam logic [1:0] HAZ_WB  = 2'b10;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int OP1_HI = 11;
    localparam int OP1_LO = 8;
    localparam int OP2_HI = 7;
    localparam int OP2_LO = 4;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } fwd_state_e;

    function automatic logic is_load(input logic [INST_W_FIXED-1:0] inst);
        logic [3:0] opc;
        opc = inst[OPC_HI:OPC_LO];
        return (opc == OP_LB) || (opc == OP_LW);
    endfunction

    // Writers: ALU, AND/OR immediate (100x), lb, lw. Stores, branches and NOP never write.
    function automatic logic is_writer(input logic [INST_W_FIXED-1:0] inst);
        logic [3:0] opc;
        opc = inst[OPC_HI:OPC_LO];
        return (opc == OP_ALU) || (opc == OP_ANDI) || (opc == OP_ORI) ||
               (opc == OP_LB)  || (opc == OP_LW);
    endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// -----------------------------------------------------------------------------
// fwd_operand_mux
// Selects one ALU operand from register file, M-stage result or WB-stage data.
// Ports:
//   sel      in  2       00/11 regfile, 01 M stage, 10 WB stage
//   rf_data  in  DATA_W  register-file read data
//   m_data   in  DATA_W  M-stage result register
//   wb_data  in  DATA_W  WB-stage write data
//   op_data  out DATA_W  selected operand
// -----------------------------------------------------------------------------
module fwd_operand_mux
    import fwd_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] m_data,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] op_data
);

    always_comb begin
        op_data = rf_data;
        case (sel)
            HAZ_M:   op_data = m_data;
            HAZ_WB:  op_data = wb_data;
            default: op_data = rf_data;
        endcase
    end

endmodule

// File: rtl/fwd_result_pipe.sv
// -----------------------------------------------------------------------------
// fwd_result_pipe
// Producer side of operand forwarding. Owns the EX->M and M->WB result
// registers, publishes inst_m/inst_wb to the forwarding unit, applies the
// haz1/haz2 selects to the ALU operand muxes and drives the regfile write port.
//
// Configuration macro: FWD_LOADUSE_STALL_EN
//   defined   : load-use detection with a RUN/HOLD FSM inserting one stall cycle
//   undefined : stall tied low; software must place a NOP after each load
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ex_valid/ex_inst   EX-stage instruction and its valid bit
//   ex_result          ALU result / store address of ex_inst
//   rf_op1, rf_op2     register-file read data
//   haz1, haz2         forwarding selects (00 rf, 01 M, 10 WB, 11 rf)
//   mem_rdata          data-memory read data for the instruction in M
//   inst_m, inst_wb    M / WB instruction registers
//   op1_data, op2_data forwarded ALU operands
//   stall              hold IF/ID/EX this cycle
//   wb_we/addr/data    register-file write port
//
// FSM (only with FWD_LOADUSE_STALL_EN):
//   state   | meaning
//   ST_RUN  | normal flow; load-use here stalls for this cycle
//   ST_HOLD | load now in WB, forwarded from WB; no stall
// -----------------------------------------------------------------------------
module fwd_result_pipe
    import fwd_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [INST_W-1:0] ex_inst,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] rf_op1,
    input  logic [DATA_W-1:0] rf_op2,
    input  logic [1:0]        haz1,
    input  logic [1:0]        haz2,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [INST_W-1:0] inst_m,
    output logic [INST_W-1:0] inst_wb,
    output logic [DATA_W-1:0] op1_data,
    output logic [DATA_W-1:0] op2_data,
    output logic              stall,
    output logic              wb_we,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data
);

    logic [INST_W-1:0] inst_m_q,    inst_m_d;
    logic              m_valid_q,   m_valid_d;
    logic [DATA_W-1:0] m_result_q,  m_result_d;
    logic [INST_W-1:0] inst_wb_q,   inst_wb_d;
    logic              wb_valid_q,  wb_valid_d;
    logic [DATA_W-1:0] wb_result_q, wb_result_d;
    logic              stall_int;

`ifdef FWD_LOADUSE_STALL_EN
    fwd_state_e state_q, state_d;
    logic       load_use;

    // A load in M has only its address in m_result; consumers selecting M must wait.
    assign load_use = is_load(inst_m_q) && m_valid_q &&
                      ((haz1 == HAZ_M) || (haz2 == HAZ_M));

    always_comb begin
        state_d   = state_q;
        stall_int = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (load_use) begin
                    state_d   = ST_HOLD;
                    stall_int = 1'b1;
                end
            end
            ST_HOLD: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign stall_int = 1'b0;
`endif

    always_comb begin
        // A stall inserts a bubble into M while EX is held upstream.
        if (stall_int) begin
            inst_m_d   = '0;
            m_valid_d  = 1'b0;
            m_result_d = '0;
        end else begin
            inst_m_d   = ex_valid ? ex_inst : '0;
            m_valid_d  = ex_valid;
            m_result_d = ex_result;
        end
        inst_wb_d   = inst_m_q;
        wb_valid_d  = m_valid_q;
        wb_result_d = is_load(inst_m_q) ? mem_rdata : m_result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_m_q    <= '0;
            m_valid_q   <= 1'b0;
            m_result_q  <= '0;
            inst_wb_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_result_q <= '0;
        end else begin
            inst_m_q    <= inst_m_d;
            m_valid_q   <= m_valid_d;
            m_result_q  <= m_result_d;
            inst_wb_q   <= inst_wb_d;
            wb_valid_q  <= wb_valid_d;
            wb_result_q <= wb_result_d;
        end
    end

    fwd_operand_mux #(.DATA_W(DATA_W)) u_mux_op1 (
        .sel     (haz1),
        .rf_data (rf_op1),
        .m_data  (m_result_q),
        .wb_data (wb_result_q),
        .op_data (op1_data)
    );

    fwd_operand_mux #(.DATA_W(DATA_W)) u_mux_op2 (
        .sel     (haz2),
        .rf_data (rf_op2),
        .m_data  (m_result_q),
        .wb_data (wb_result_q),
        .op_data (op2_data)
    );

    assign inst_m  = inst_m_q;
    assign inst_wb = inst_wb_q;
    assign stall   = stall_int;
    assign wb_we   = wb_valid_q && is_writer(inst_wb_q);
    assign wb_addr = inst_wb_q[OP1_HI:OP1_LO];
    assign wb_data = wb_result_q;

endmodule
